// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional byte-enable feature is selected with DM_BYTE_EN_EN.
package dm_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Misaligned byte address or word index beyond the stored words.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store bus between the core's memory stage (master) and the responder (slave).
// req_be exists only when DM_BYTE_EN_EN is defined.
interface dm_responder_if;
  import dm_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DM_BYTE_EN_EN
  logic [BE_W-1:0]   req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
`ifdef DM_BYTE_EN_EN
    output req_be,
`endif
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
`ifdef DM_BYTE_EN_EN
    input  req_be,
`endif
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, error on bad address.
// Byte-lane stores are enabled with DM_BYTE_EN_EN; otherwise every store writes the full word.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dm_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end

  state_e            state_d, state_q;
  logic [3:0]        cnt_d, cnt_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              err_d, err_q;
  logic [BE_W-1:0]   ram_be;
  logic              ram_we, ram_re, bad;
  logic [DATA_W-1:0] ram_rdata;

`ifdef DM_BYTE_EN_EN
  logic [BE_W-1:0]   be_d, be_q;
  assign ram_be = be_q;
`else
  assign ram_be = '1;
`endif

  assign bad = addr_bad(addr_q, DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
`ifdef DM_BYTE_EN_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DM_BYTE_EN_EN
          be_d    = bus.req_be;
`endif
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Store is gated by rst_n so a reset landing on this edge aborts it;
          // the load is issued here so the registered RAM output is valid in RESP.
          ram_we  = we_q && !bad && rst_n;
          ram_re  = !we_q && !bad;
          err_d   = bad;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DM_BYTE_EN_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef DM_BYTE_EN_EN
      be_q    <= be_d;
`endif
    end
  end

  dm_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[2 +: AW]),
    .be    (ram_be),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = (state_q == ST_RESP && !we_q && !err_q) ? ram_rdata : ERR_RDATA;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: one instance with 2 wait states, one with none.
// Byte-lane checks run only when DM_BYTE_EN_EN is defined.
module tb_dm_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  dm_responder_if b2 ();
  dm_responder_if b0 ();

  dm_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  dm_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DM_BYTE_EN_EN
  logic [3:0] txn_be;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after an edge with the wait-2 instance idle; leaves it idle again.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    b2.req_valid  = 1'b1;
    b2.req_we     = we;
    b2.req_addr   = addr;
    b2.req_wdata  = wdata;
`ifdef DM_BYTE_EN_EN
    b2.req_be     = txn_be;
`endif
    b2.resp_ready = 1'b1;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    b2.req_we    = ~we;
    b2.req_addr  = 32'hFFFF_FFFF;
    b2.req_wdata = 32'h0;
    lat = 0;
    while (!b2.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = b2.resp_rdata;
    err   = b2.resp_err;
    @(posedge clk); #1;
    check("ack_drop", {31'b0, b2.resp_valid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          prev_acc;
  logic        w0_we    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] w0_addr  [4] = '{32'h8, 32'hC, 32'h8, 32'hC};
  logic [31:0] w0_wdata [4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0, 32'h0};
  logic [31:0] w0_exp   [4] = '{32'h0, 32'h0, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0; b2.resp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1'b0;
`ifdef DM_BYTE_EN_EN
    txn_be = 4'hF;
    b2.req_be = 4'hF;
    b0.req_be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_req_ready",  {31'b0, b2.req_ready},  32'h1);
    check("rst_resp_valid", {31'b0, b2.resp_valid}, 32'h0);
    check("rst_resp_rdata", b2.resp_rdata,          32'h0);
    check("rst_resp_err",   {31'b0, b2.resp_err},   32'h0);

    txn(1'b1, 32'h10, 32'h1234_5678, rd, er, lat);
    txn(1'b1, 32'h00, 32'h0102_0304, rd, er, lat);

    // Reset held three cycles while a store to 0x10 sits in WAIT.
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 32'h10; b2.req_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midwait_rst_ready", {31'b0, b2.req_ready}, 32'h1);
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("midwait_rst_data", rd, 32'h1234_5678);

    txn(1'b1, 32'h20, 32'hDEAD_BEEF, rd, er, lat);
    check("st_latency", 32'(lat), 32'd3);
    check("st_err",     {31'b0, er}, 32'h0);
    check("st_rdata",   rd, 32'h0);
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_rdata",   rd, 32'hDEAD_BEEF);

    txn(1'b0, 32'h22, 32'h0, rd, er, lat);
    check("misal_err",   {31'b0, er}, 32'h1);
    check("misal_rdata", rd, 32'h0);
    check("misal_lat",   32'(lat), 32'd3);
    txn(1'b1, 32'h100, 32'hCAFE_F00D, rd, er, lat);
    check("oor_err", {31'b0, er}, 32'h1);
    check("oor_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h00, 32'h0, rd, er, lat);
    check("oor_word0_kept", rd, 32'h0102_0304);
    check("word0_err",      {31'b0, er}, 32'h0);

    // Backpressure on a load of 0x20 with a competing store presented meanwhile.
    b2.resp_ready = 1'b0;
    b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 32'h20;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    lat = 0;
    while (!b2.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd3);
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 32'h20; b2.req_wdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, b2.resp_valid}, 32'h1);
      check("bp_rdata", b2.resp_rdata, 32'hDEAD_BEEF);
      check("bp_err",   {31'b0, b2.resp_err}, 32'h0);
      check("bp_ready", {31'b0, b2.req_ready}, 32'h0);
    end
    b2.req_valid  = 1'b0;
    b2.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", {31'b0, b2.resp_valid}, 32'h0);
    check("bp_done_rdata", b2.resp_rdata, 32'h0);
    check("bp_done_ready", {31'b0, b2.req_ready}, 32'h1);
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'hDEAD_BEEF);

    // Zero wait states, req_valid held high throughout.
    prev_acc = 0;
    b0.resp_ready = 1'b1;
    b0.req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b0.req_we    = w0_we[i];
      b0.req_addr  = w0_addr[i];
      b0.req_wdata = w0_wdata[i];
      check("w0_ready", {31'b0, b0.req_ready}, 32'h1);
      if (i > 0) check("w0_spacing", 32'(cyc - prev_acc), 32'd3);
      prev_acc = cyc;
      @(posedge clk); #1;
      check("w0_wait_valid", {31'b0, b0.resp_valid}, 32'h0);
      @(posedge clk); #1;
      check("w0_resp_valid", {31'b0, b0.resp_valid}, 32'h1);
      check("w0_resp_rdata", b0.resp_rdata, w0_exp[i]);
      check("w0_resp_err",   {31'b0, b0.resp_err}, 32'h0);
      @(posedge clk); #1;
    end
    b0.req_valid = 1'b0;

`ifdef DM_BYTE_EN_EN
    txn_be = 4'hF;
    txn(1'b1, 32'h04, 32'h1122_3344, rd, er, lat);
    txn_be = 4'b0101;
    txn(1'b1, 32'h04, 32'hAABB_CCDD, rd, er, lat);
    check("be_st_err", {31'b0, er}, 32'h0);
    txn_be = 4'b0000;
    txn(1'b1, 32'h04, 32'h0000_0000, rd, er, lat);
    check("be_noop_err", {31'b0, er}, 32'h0);
    check("be_noop_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h04, 32'h0, rd, er, lat);
    check("be_merge", rd, 32'h11BB_33DD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
